mux_4to1: RTL and testbench
===========================

Name: mux_4to1

Overview:
- 4-input, 1-output selector. Drives lane `in[sel]` combinationally on `out`.
- Also provides a registered, valid-qualified copy of the selected lane for downstream pipelined logic.
- Leaf datapath block; used wherever a 2-bit select picks one of four equal-width sources.

Parameters:
- WIDTH, 1, bit width of each input lane and of out/out_q.

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst  input  1  synchronous, active-high reset.
- in  input  4*WIDTH  four packed lanes; lane k = in[k*WIDTH +: WIDTH]; lane 0 in the LSBs.
- sel  input  2  lane select; 0 selects lane 0, 3 selects lane 3.
- in_valid  input  1  qualifies in/sel for capture into the registered path.
- out  output  WIDTH  combinational selected lane.
- out_q  output  WIDTH  registered selected lane.
- out_valid  output  1  out_q holds data captured from a valid cycle.

Behaviour:
- Combinational path:
  - out = lane[sel], purely combinational, zero latency.
  - Independent of clk, rst and in_valid.
  - Any change on in or sel updates out within the same delta/timestep.
- All four sel codes are legal; there is no out-of-range case.
- If sel contains X/Z, out is X in simulation. No default-lane masking.
- Registered path, on each rising clk edge:
  - rst=1: out_q <= 0, out_valid <= 0.
  - rst=0, in_valid=1: out_q <= lane[sel] (same value as out that cycle); out_valid <= 1.
  - rst=0, in_valid=0: out_q holds its value; out_valid <= 0.
- Latency of the registered path: 1 cycle from in_valid high to out_valid high with the matching data.
- Back-to-back valid cycles produce back-to-back out_valid cycles. There is no backpressure and no ready signal.
- Reset asserted mid-stream clears out_q and out_valid on the same edge; a coincident in_valid is dropped.
- Reset does not affect the combinational out.
- No state machine. No arithmetic. Widths match exactly; no truncation or extension.

Optional Feature:
- Macro: MUX_4TO1_PARITY_EN.
- When defined:
  - Extra output port out_par (1 bit) = even parity (XOR reduction) of out_q.
  - out_par is registered alongside out_q under the same capture and hold rules.
  - Reset value of out_par is 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mux_4to1_pkg:
  - NUM_LANES = 4 and SEL_W = 2 constants.
  - typedef sel_t (logic [SEL_W-1:0]).
  - Lane-index helper constants used by the bench.
- One natural sub-module, mux_4to1_core: purely combinational lane selector (in, sel -> out).
  - The top instantiates it once and adds the output register, valid flop and optional parity flop.

Test Plan:
- WIDTH=1 one-hot walk, combinational path: (sel=0, in=0001), (sel=1, in=0010), (sel=2, in=0100), (sel=3, in=1000) -> out=1 each step, 10 ns apart.
- WIDTH=1 inverted patterns: (sel=0, in=1110), (sel=1, in=1101), (sel=2, in=1011) -> out=0 each. Then (sel=3, in=0110) -> out=0.
- Registered path, WIDTH=8, in={8'hDD,8'hCC,8'hBB,8'hAA}:
  - Sweep sel 0..3 with in_valid=1 over four cycles -> out_q = AA, BB, CC, DD one cycle later each, with out_valid=1 on each.
- in_valid=0 for 3 cycles after capturing 8'hBB -> out_q stays 8'hBB and out_valid=0 while in/sel toggle; out still tracks the inputs combinationally.
- Reset:
  - Assert rst with in_valid=1 and sel=3 -> next edge out_q=0, out_valid=0.
  - Deassert -> the next valid capture works normally.
  - Reset at time 0 gives out_q=0, out_valid=0.
- With MUX_4TO1_PARITY_EN defined, WIDTH=8:
  - Capture 8'h07 -> out_par=1.
  - Capture 8'h03 -> out_par=0.
  - Reset -> out_par=0.

Source files
------------

// File: rtl/mux_4to1_pkg.sv
// Shared constants and select type for the 4-to-1 lane selector.
package mux_4to1_pkg;
  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t LANE0 = 2'd0;
  localparam sel_t LANE1 = 2'd1;
  localparam sel_t LANE2 = 2'd2;
  localparam sel_t LANE3 = 2'd3;
endpackage

// File: rtl/mux_4to1_core.sv
// Purely combinational selector: drives lane[sel] of a packed 4-lane bus.
module mux_4to1_core
  import mux_4to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [NUM_LANES*WIDTH-1:0] in,
  input  sel_t                       sel,
  output logic [WIDTH-1:0]           out
);

  // An unknown select propagates X rather than masking to a default lane.
  always_comb begin
    out = 'x;
    case (sel)
      LANE0:   out = in[0*WIDTH +: WIDTH];
      LANE1:   out = in[1*WIDTH +: WIDTH];
      LANE2:   out = in[2*WIDTH +: WIDTH];
      LANE3:   out = in[3*WIDTH +: WIDTH];
      default: out = 'x;
    endcase
  end

endmodule

// File: rtl/mux_4to1.sv
// 4-to-1 lane selector with a combinational output and a registered, valid-qualified copy.
// Optional registered parity output out_par is enabled by defining MUX_4TO1_PARITY_EN.
module mux_4to1
  import mux_4to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LANES*WIDTH-1:0] in,
  input  sel_t                       sel,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           out,
  output logic [WIDTH-1:0]           out_q,
  output logic                       out_valid
`ifdef MUX_4TO1_PARITY_EN
  ,
  output logic                       out_par
`endif
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             vld_d, vld_q;

  mux_4to1_core #(.WIDTH(WIDTH)) u_core (
    .in  (in),
    .sel (sel),
    .out (out)
  );

  always_comb begin
    data_d = data_q;
    vld_d  = in_valid;
    if (in_valid) data_d = out;
  end

  // Stage p0 -> p1: capture the selected lane; the valid flag is not sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign out_q     = data_q;
  assign out_valid = vld_q;

`ifdef MUX_4TO1_PARITY_EN
  logic par_d, par_q;

  always_comb begin
    par_d = par_q;
    if (in_valid) par_d = ^out;
  end

  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  assign out_par = par_q;
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// Directed and randomized bench for mux_4to1 at WIDTH=1 and WIDTH=8 against a lane-arithmetic model.
module tb_mux_4to1;
  import mux_4to1_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;

  logic [3:0]  in1;
  sel_t        sel1;
  logic        out1, q1, v1;

  logic [31:0] in8;
  sel_t        sel8;
  logic [7:0]  out8, q8;
  logic        v8;

`ifdef MUX_4TO1_PARITY_EN
  logic        par1, par8;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_q;
  logic        m_v;

  always #5 clk = ~clk;

  mux_4to1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in(in1), .sel(sel1), .in_valid(in_valid),
    .out(out1), .out_q(q1), .out_valid(v1)
`ifdef MUX_4TO1_PARITY_EN
    , .out_par(par1)
`endif
  );

  mux_4to1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in(in8), .sel(sel8), .in_valid(in_valid),
    .out(out8), .out_q(q8), .out_valid(v8)
`ifdef MUX_4TO1_PARITY_EN
    , .out_par(par8)
`endif
  );

  function automatic logic [7:0] lane8(input logic [31:0] v, input int s);
    return 8'((v >> (8 * s)) & 32'hFF);
  endfunction

  function automatic logic lane1(input logic [3:0] v, input int s);
    return v[s];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, updating the model from the inputs present at the edge.
  task automatic cycle();
    logic [7:0] nq;
    logic       nv;
    if (rst) begin
      nq = 8'h00; nv = 1'b0;
    end else if (in_valid) begin
      nq = lane8(in8, int'(sel8)); nv = 1'b1;
    end else begin
      nq = m_q; nv = 1'b0;
    end
    @(posedge clk);
    m_q = nq;
    m_v = nv;
    #1;
  endtask

  task automatic chk_reg(input string tag);
    chk({tag, "_q"}, q8, m_q);
    chk({tag, "_v"}, {7'd0, v8}, {7'd0, m_v});
`ifdef MUX_4TO1_PARITY_EN
    chk({tag, "_par"}, {7'd0, par8}, {7'd0, ^m_q});
`endif
  endtask

  initial begin
    m_q = 8'h00; m_v = 1'b0;
    rst = 1'b1; in_valid = 1'b0;
    in1 = 4'h0; sel1 = LANE0;
    in8 = 32'h0; sel8 = LANE0;

    // Reset from time zero.
    cycle();
    chk("rst0_q8", q8, 8'h00);
    chk("rst0_v8", {7'd0, v8}, 8'h00);
    chk("rst0_q1", {7'd0, q1}, 8'h00);
    chk("rst0_v1", {7'd0, v1}, 8'h00);
`ifdef MUX_4TO1_PARITY_EN
    chk("rst0_par", {7'd0, par8}, 8'h00);
`endif
    rst = 1'b0;

    // WIDTH=1 one-hot walk and inverted patterns on the combinational path.
    sel1 = LANE0; in1 = 4'b0001; #10; chk("walk0", {7'd0, out1}, 8'd1);
    sel1 = LANE1; in1 = 4'b0010; #10; chk("walk1", {7'd0, out1}, 8'd1);
    sel1 = LANE2; in1 = 4'b0100; #10; chk("walk2", {7'd0, out1}, 8'd1);
    sel1 = LANE3; in1 = 4'b1000; #10; chk("walk3", {7'd0, out1}, 8'd1);
    sel1 = LANE0; in1 = 4'b1110; #10; chk("inv0", {7'd0, out1}, 8'd0);
    sel1 = LANE1; in1 = 4'b1101; #10; chk("inv1", {7'd0, out1}, 8'd0);
    sel1 = LANE2; in1 = 4'b1011; #10; chk("inv2", {7'd0, out1}, 8'd0);
    sel1 = LANE3; in1 = 4'b0110; #10; chk("inv3", {7'd0, out1}, 8'd0);

    // Registered sweep, back-to-back valid.
    @(posedge clk); #1;
    in8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    in_valid = 1'b1;
    for (int s = 0; s < NUM_LANES; s++) begin
      sel8 = sel_t'(s);
      #1;
      chk("sweep_comb", out8, lane8(in8, s));
      cycle();
      chk_reg("sweep");
    end
    chk("sweep_last", q8, 8'hDD);

    // Capture BB then hold for three idle cycles with toggling inputs.
    sel8 = LANE1; cycle(); chk("cap_bb", q8, 8'hBB);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in8  = $urandom;
      sel8 = sel_t'($urandom_range(0, 3));
      #1;
      chk("hold_comb", out8, lane8(in8, int'(sel8)));
      cycle();
      chk("hold_q", q8, 8'hBB);
      chk("hold_v", {7'd0, v8}, 8'h00);
    end

    // Mid-stream reset drops a coincident valid.
    in8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    rst = 1'b1; in_valid = 1'b1; sel8 = LANE3;
    #1; chk("rst_comb", out8, 8'hDD);
    cycle();
    chk("rst_mid_q", q8, 8'h00);
    chk("rst_mid_v", {7'd0, v8}, 8'h00);
    rst = 1'b0; sel8 = LANE2;
    cycle();
    chk("post_rst_q", q8, 8'hCC);
    chk("post_rst_v", {7'd0, v8}, 8'h01);

    // Parity-oriented captures.
    sel8 = LANE0; in8 = {24'h0, 8'h07}; cycle(); chk_reg("cap07");
    in8 = {24'h0, 8'h03}; cycle(); chk_reg("cap03");
    in8 = {24'h0, 8'h07}; cycle();
    rst = 1'b1; cycle(); chk_reg("par_rst");
    rst = 1'b0;

    // Randomized traffic on both widths.
    for (int i = 0; i < 60; i++) begin
      in8      = $urandom;
      sel8     = sel_t'($urandom_range(0, 3));
      in1      = 4'($urandom);
      sel1     = sel_t'($urandom_range(0, 3));
      in_valid = 1'($urandom);
      rst      = ($urandom_range(0, 15) == 0);
      #1;
      chk("rnd_comb8", out8, lane8(in8, int'(sel8)));
      chk("rnd_comb1", {7'd0, out1}, {7'd0, lane1(in1, int'(sel1))});
      cycle();
      chk_reg("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
